// File: rtl/branch_predictor_gshare_pkg.sv
// rtl/branch_predictor_gshare_pkg.sv - shared types and counter helpers for the gshare branch predictor
package bp_pkg;

    localparam int unsigned CTR_W_MAX = 4;
    localparam int unsigned ADDR_W    = 32;

    // Tag is held at full address width; bits above TAG_WIDTH are always zero.
    typedef struct packed {
        logic              valid;
        logic              uncond;
        logic [ADDR_W-1:0] tag;
        logic [ADDR_W-1:0] target;
    } btb_entry_t;

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int unsigned width);
        return CTR_W_MAX'((1 << width) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_reset(input int unsigned width);
        return CTR_W_MAX'((1 << (width - 1)) - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] sat_update(
        input logic [CTR_W_MAX-1:0] counter,
        input logic                 taken,
        input logic [CTR_W_MAX-1:0] max
    );
        if (taken) begin
            return (counter >= max) ? max : counter + 4'd1;
        end
        return (counter == 4'd0) ? 4'd0 : counter - 4'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter_table.sv
// rtl/branch_predictor_gshare_sat_counter_table.sv - PHT of saturating counters, async read, sync write
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH   = 6,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_WIDTH-1:0]   rd_index,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [INDEX_WIDTH-1:0]   wr_index,
    input  logic                     wr_taken
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_W_MAX-1:0]     CTR_MAX = ctr_max(COUNTER_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] CTR_RST = COUNTER_WIDTH'(ctr_reset(COUNTER_WIDTH));

    if (COUNTER_WIDTH < 2 || COUNTER_WIDTH > 4) begin : g_bad_counter_width
        $error("sat_counter_table: COUNTER_WIDTH must be in 2..4");
    end

    logic [COUNTER_WIDTH-1:0] ctr [DEPTH];
    logic [COUNTER_WIDTH-1:0] wr_next;

    assign rd_data = ctr[rd_index];
    assign wr_next = COUNTER_WIDTH'(sat_update(CTR_W_MAX'(ctr[wr_index]), wr_taken, CTR_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_RST;
            end
        end else if (wr_en) begin
            ctr[wr_index] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - IF-stage gshare/bimodal direction predictor with tagged BTB, trained from JB
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH   = 6,
    parameter int HISTORY_WIDTH = 6,
    parameter int TAG_WIDTH     = 8,
    parameter int COUNTER_WIDTH = 2,
    parameter bit GSHARE        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              lk_pc,
    output logic                     lk_pred_taken,
    output logic [31:0]              lk_pred_target,
    output logic                     lk_btb_hit,
    output logic [INDEX_WIDTH-1:0]   lk_pht_index,
    input  logic                     upd_valid,
    input  logic [31:0]              upd_pc,
    input  logic [INDEX_WIDTH-1:0]   upd_pht_index,
    input  logic                     upd_uncond,
    input  logic                     upd_taken,
    input  logic [31:0]              upd_target,
    input  logic                     upd_mispredict,
    output logic [HISTORY_WIDTH-1:0] ghr,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    if (HISTORY_WIDTH < 1 || HISTORY_WIDTH > INDEX_WIDTH) begin : g_bad_history_width
        $error("branch_predictor_gshare: HISTORY_WIDTH must be in 1..INDEX_WIDTH");
    end
    if (INDEX_WIDTH + TAG_WIDTH + 2 > 32) begin : g_bad_tag_width
        $error("branch_predictor_gshare: index plus tag exceed the PC width");
    end

    logic [INDEX_WIDTH-1:0]   lk_btb_idx;
    logic [TAG_WIDTH-1:0]     lk_tag;
    logic [INDEX_WIDTH-1:0]   upd_btb_idx;
    logic [TAG_WIDTH-1:0]     upd_tag;
    logic [COUNTER_WIDTH-1:0] pht_rd;
    logic [HISTORY_WIDTH-1:0] ghr_next;
    logic                     cond_upd;
    btb_entry_t               btb [DEPTH];
    btb_entry_t               lk_entry;
    logic                     lint_unused;

    assign lk_btb_idx  = lk_pc[INDEX_WIDTH+1:2];
    assign lk_tag      = lk_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
    assign upd_btb_idx = upd_pc[INDEX_WIDTH+1:2];
    assign upd_tag     = upd_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
    assign cond_upd    = upd_valid && !upd_uncond;

    // Only the counter MSB feeds the prediction; PC bits outside index/tag are ignored.
    assign lint_unused = ^{lk_pc, upd_pc, pht_rd};

    assign lk_pht_index = GSHARE ? (lk_btb_idx ^ INDEX_WIDTH'(ghr)) : lk_btb_idx;

    sat_counter_table #(
        .INDEX_WIDTH  (INDEX_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_pht (
        .clk     (clk),
        .rst     (rst),
        .rd_index(lk_pht_index),
        .rd_data (pht_rd),
        .wr_en   (cond_upd),
        .wr_index(upd_pht_index),
        .wr_taken(upd_taken)
    );

    assign lk_entry       = btb[lk_btb_idx];
    assign lk_btb_hit     = lk_entry.valid && (lk_entry.tag == ADDR_W'(lk_tag));
    assign lk_pred_taken  = lk_btb_hit && (lk_entry.uncond || pht_rd[COUNTER_WIDTH-1]);
    assign lk_pred_target = lk_btb_hit ? lk_entry.target : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i].valid <= 1'b0;
            end
        end else if (upd_valid && upd_taken) begin
            btb[upd_btb_idx] <= '{valid: 1'b1, uncond: upd_uncond,
                                  tag: ADDR_W'(upd_tag), target: upd_target};
        end
    end

    if (HISTORY_WIDTH == 1) begin : g_ghr_single
        assign ghr_next = upd_taken;
    end else begin : g_ghr_shift
        assign ghr_next = {ghr[HISTORY_WIDTH-2:0], upd_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr              <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (cond_upd) begin
                ghr <= ghr_next;
                if (branch_count != 32'hFFFF_FFFF) begin
                    branch_count <= branch_count + 32'd1;
                end
            end
            if (upd_valid && upd_mispredict && mispredict_count != 32'hFFFF_FFFF) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the 3-bit-indexed bimodal predictor currently resolved in the JB stage.
- Provides fetch-stage (IF) prediction: a pattern history table (PHT) of saturating counters, indexed bimodally or gshare-style from a global history register (GHR), plus a tagged branch target buffer (BTB).
- A predicted-taken branch or jump redirects IF_Pc in the same cycle.
- Trained from the JB stage on resolution; also keeps branch and mispredict performance counters.

Parameters:
- INDEX_WIDTH, 6, PHT and BTB index bits; each holds 2**INDEX_WIDTH entries.
- HISTORY_WIDTH, 6, GHR bits; legal range 1..INDEX_WIDTH (elaboration error otherwise).
- TAG_WIDTH, 8, BTB tag bits taken from the PC above the index.
- COUNTER_WIDTH, 2, PHT counter bits; legal range 2..4.
- GSHARE, 1, index mode: 1 = PC xor GHR, 0 = bimodal (PC only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lk_pc  in  32  IF-stage PC to predict
- lk_pred_taken  out  1  redirect fetch to lk_pred_target
- lk_pred_target  out  32  BTB target for lk_pc
- lk_btb_hit  out  1  BTB valid and tag match for lk_pc
- lk_pht_index  out  INDEX_WIDTH  PHT index used for this lookup; carried down the pipe for training
- upd_valid  in  1  one resolved control-transfer instruction this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_pht_index  in  INDEX_WIDTH  lk_pht_index captured at that instruction's fetch
- upd_uncond  in  1  1 = JAL (unconditional); 0 = conditional branch
- upd_taken  in  1  resolved direction
- upd_target  in  32  resolved target
- upd_mispredict  in  1  prediction was wrong
- ghr  out  HISTORY_WIDTH  current global history
- branch_count  out  32  conditional branches resolved
- mispredict_count  out  32  mispredictions resolved

Behaviour:
- Lookup is purely combinational, with zero latency.
  - btb_idx = lk_pc[INDEX_WIDTH+1:2]; tag = lk_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].
  - lk_pht_index = btb_idx ^ zero-extended ghr when GSHARE=1, else btb_idx.
  - lk_btb_hit = valid[btb_idx] && tag match.
  - lk_pred_taken = lk_btb_hit && (uncond[btb_idx] || pht[lk_pht_index] MSB).
  - lk_pred_target = target[btb_idx] on a hit, else 0.
- All state updates on the clk rising edge when upd_valid=1. Results are visible to lookups from the next cycle onward.
  - A same-cycle lookup of an entry being written returns the pre-write value.
- Conditional branch update (upd_uncond=0):
  - pht[upd_pht_index] saturating +1 if taken, -1 if not; it holds at 2**COUNTER_WIDTH-1 and at 0.
  - GHR <= {ghr[HISTORY_WIDTH-2:0], upd_taken}. With HISTORY_WIDTH=1, GHR <= upd_taken.
  - branch_count +1.
- JAL update (upd_uncond=1): PHT, GHR and branch_count are unchanged.
- BTB write: on every update with upd_taken=1, the entry at upd_pc's BTB index gets valid=1, tag, target and uncond=upd_uncond.
  - A not-taken update does not touch the BTB; stale entries are filtered by the counter.
- mispredict_count +1 when upd_valid && upd_mispredict, for both kinds.
- Both perf counters saturate at 32'hFFFF_FFFF.
- GHR is non-speculative (updated only on resolution); the pipeline is responsible for carrying lk_pht_index.
- JALR is never sent on upd_*; its target is handled by the JB jump adder.
- Reset:
  - Synchronous reset dominates upd_valid.
  - Clears all BTB valid bits, GHR, and both perf counters.
  - Sets every PHT counter to 2**(COUNTER_WIDTH-1)-1 (weakly not-taken).
  - Combinational outputs then read lk_btb_hit=0, lk_pred_taken=0, lk_pred_target=0.
- Reset asserted mid-training discards that cycle's update entirely.

Decomposition:
- Package bp_pkg: localparams for counter max and reset value, a btb_entry_t struct {valid, uncond, tag, target}, and the function sat_update(counter, taken).
- One sub-module, sat_counter_table: the PHT array with combinational read port, write port and synchronous reset init.
- The BTB, GHR and perf counters stay in the top module.

Test Plan:
- Reset, then lookup lk_pc=0x40 -> lk_btb_hit=0, lk_pred_taken=0, ghr=0, counters 0; lk_pht_index=0x10.
- GSHARE=0. Conditional taken update at pc 0x40 with target 0x20 -> next cycle lookup 0x40 gives hit=1, PHT 01->10, pred_taken=1, target 0x20, branch_count=1.
- Same entry: 4 more taken updates -> counter stuck at 11. Then 2 not-taken updates -> 10 (still taken), then 01 -> pred_taken=0 with hit=1.
- GSHARE=1. Conditional updates with taken pattern T,N,T -> ghr=0b000101; lookup 0x40 -> lk_pht_index=0x15.
- JAL update pc 0x40, target 0x80 -> hit, pred_taken=1 regardless of counter, ghr unchanged. Lookup 0x140 (same index, different tag) -> hit=0, pred_taken=0.
- Same-cycle boundary cases:
  - Update and lookup of pc 0x40 in the same cycle -> old prediction returned that cycle, new prediction the next.
  - rst=1 with upd_valid=1, upd_mispredict=1 -> mispredict_count=0, BTB invalid.
